// File: rtl/spi_flash_if.sv
// SPI pad bundle between the SoC-side master and the flash responder.
interface spi_flash_if;
  logic csb;
  logic sclk;
  logic io0;
  logic io1;
  logic io1_oe;

  modport master (output csb, sclk, io0, input io1, io1_oe);
  modport slave  (input csb, sclk, io0, output io1, io1_oe);
endinterface

// File: rtl/spi_flash.sv
// Read-only SPI NOR flash responder (mode 0, MSB first, single-bit), oversampled by clock.
// Optional fast read (0x0B + 8 dummy clocks) is built when SPI_FLASH_FAST_READ_EN is defined.
module spi_flash #(
  parameter string FILENAME    = "firmware.hex",
  parameter int    ADDR_BITS   = 12,
  parameter int    SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  spi_flash_if.slave spi
);
  localparam int RXW = (ADDR_BITS > 8) ? ADDR_BITS : 8;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [7:0] OP_PWR_UP = 8'hAB;
  localparam logic [7:0] OP_PWR_DN = 8'hB9;
  localparam logic [7:0] OP_READ   = 8'h03;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OP_FAST   = 8'h0B;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_IGNORE = 3'd4
`ifdef SPI_FLASH_FAST_READ_EN
    , S_DUMMY = 3'd5
`endif
  } state_e;

  logic [7:0] mem [2**ADDR_BITS];

  logic [SYNC_STAGES-1:0] csb_sync_q, sclk_sync_q, io0_sync_q;
  logic                   sclk_prev_q;
  logic                   csb_s, sclk_s, io0_s, sclk_rise, sclk_fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      csb_sync_q  <= '1;
      sclk_sync_q <= '0;
      io0_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi.csb};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      io0_sync_q  <= {io0_sync_q[SYNC_STAGES-2:0], spi.io0};
      sclk_prev_q <= sclk_s;
    end
  end

  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign io0_s     = io0_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [RXW-2:0]         rx_q, rx_d;
  logic [RXW-1:0]         rx_full;
  logic [ADDR_BITS-1:0]   addr_q, addr_d, rd_addr;
  logic                   pwr_q, pwr_d;
  logic [7:0]             tx_q, tx_d, rdata_q;
  logic                   io1_q, io1_d, oe_q, oe_d, rd_en;
`ifdef SPI_FLASH_FAST_READ_EN
  logic                   fast_q, fast_d;
`endif

  // Only the low address bits survive the shift; upper bits fall off the end.
  assign rx_full = {rx_q, io0_s};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      addr_q  <= '0;
      pwr_q   <= 1'b0;
      tx_q    <= '0;
      io1_q   <= 1'b0;
      oe_q    <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      addr_q  <= addr_d;
      pwr_q   <= pwr_d;
      tx_q    <= tx_d;
      io1_q   <= io1_d;
      oe_q    <= oe_d;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q  <= fast_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (rd_en) rdata_q <= mem[rd_addr];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    addr_d  = addr_q;
    pwr_d   = pwr_q;
    tx_d    = tx_q;
    io1_d   = io1_q;
    oe_d    = oe_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
`ifdef SPI_FLASH_FAST_READ_EN
    fast_d  = fast_q;
`endif
    // Deselect has priority over any coincident sclk edge.
    if (csb_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      io1_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
        S_CMD: if (sclk_rise) begin
          rx_d  = rx_full[RXW-2:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            state_d = S_IGNORE;
            case (rx_full[7:0])
              OP_PWR_UP: pwr_d = 1'b1;
              OP_PWR_DN: pwr_d = 1'b0;
              OP_READ: if (pwr_q) begin
                state_d = S_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                fast_d  = 1'b0;
`endif
              end
`ifdef SPI_FLASH_FAST_READ_EN
              OP_FAST: if (pwr_q) begin
                state_d = S_ADDR;
                fast_d  = 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        S_ADDR: if (sclk_rise) begin
          rx_d  = rx_full[RXW-2:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d   = '0;
            addr_d  = rx_full[ADDR_BITS-1:0];
            rd_en   = 1'b1;
            rd_addr = rx_full[ADDR_BITS-1:0];
`ifdef SPI_FLASH_FAST_READ_EN
            state_d = fast_q ? S_DUMMY : S_DATA;
`else
            state_d = S_DATA;
`endif
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        S_DUMMY: if (sclk_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
`endif
        // Bit 0 of each byte loads the freshly read word; the next read is
        // issued after the last bit so it lands well before the following fall.
        S_DATA: if (sclk_fall) begin
          oe_d  = 1'b1;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd0) begin
            io1_d = rdata_q[7];
            tx_d  = {rdata_q[6:0], 1'b0};
          end else begin
            io1_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            addr_d  = addr_q + ADDR_ONE;
            rd_en   = 1'b1;
            rd_addr = addr_q + ADDR_ONE;
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign spi.io1    = io1_q;
  assign spi.io1_oe = oe_q;
endmodule

// File: tb/tb_spi_flash.sv
// Scoreboard bench for spi_flash: stimulus queues expected bytes, a monitor checks io1 per byte.
module tb_spi_flash;
  localparam int SYNC = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spi_flash_if spi_bus ();

  spi_flash #(.FILENAME(""), .ADDR_BITS(12), .SYNC_STAGES(SYNC)) dut (
    .clock (clock),
    .reset (reset),
    .spi   (spi_bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       oe_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: master samples io1 on each sclk rise while the pad is driven.
  initial begin : monitor
    logic [7:0] sh;
    int         nb;
    logic [7:0] e;
    sh = '0;
    nb = 0;
    forever begin
      @(posedge spi_bus.sclk);
      if (spi_bus.csb || reset || !spi_bus.io1_oe) nb = 0;
      else begin
        sh = {sh[6:0], spi_bus.io1};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %h expected none", sh);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", {24'h0, sh}, {24'h0, e});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic half();
    repeat (4) @(negedge clock);
  endtask

  task automatic spi_bit(input logic b);
    spi_bus.io0 = b;
    half();
    spi_bus.sclk = 1'b1;
    oe_seen = oe_seen | spi_bus.io1_oe;
    half();
    spi_bus.sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic spi_zeros(input int n);
    for (int i = 0; i < n; i++) spi_bit(1'b0);
  endtask

  task automatic cs_low();
    spi_bus.csb = 1'b0;
    oe_seen = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    spi_bus.csb = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic command(input logic [7:0] op);
    cs_low();
    spi_byte(op);
    cs_high();
  endtask

  task automatic read_hdr(input logic [7:0] op, input logic [23:0] a);
    cs_low();
    spi_byte(op);
    spi_byte(a[23:16]);
    spi_byte(a[15:8]);
    spi_byte(a[7:0]);
  endtask

  initial begin : stim
    spi_bus.csb  = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.io0  = 1'b0;
    oe_seen      = 1'b0;
    reset        = 1'b1;
    dut.mem[12'h004] = 8'h13;
    dut.mem[12'h005] = 8'h57;
    dut.mem[12'h006] = 8'h9B;
    dut.mem[12'h007] = 8'hDF;
    dut.mem[12'hFFF] = 8'hA5;
    dut.mem[12'h000] = 8'h6F;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_io1", {31'h0, spi_bus.io1}, 32'h0);
    check("reset_oe", {31'h0, spi_bus.io1_oe}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Read before power-up must stay silent
    read_hdr(8'h03, 24'h000000);
    spi_zeros(8);
    check("pwrdn_read_oe", {31'h0, oe_seen}, 32'h0);
    cs_high();

    command(8'hAB);

    exp_q.push_back(8'h13);
    exp_q.push_back(8'h57);
    exp_q.push_back(8'h9B);
    exp_q.push_back(8'hDF);
    read_hdr(8'h03, 24'h000004);
    spi_zeros(32);
    cs_high();

    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h6F);
    read_hdr(8'h03, 24'h000FFF);
    spi_zeros(16);
    cs_high();

    // Abort after 12 address bits, then a clean read
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_zeros(4);
    half();
    spi_bus.csb = 1'b1;
    repeat (SYNC + 1) @(posedge clock);
    #1;
    check("abort_addr_oe", {31'h0, spi_bus.io1_oe}, 32'h0);
    repeat (8) @(negedge clock);
    exp_q.push_back(8'h13);
    read_hdr(8'h03, 24'h000004);
    spi_zeros(8);
    cs_high();

    // Abort mid-data: pad must release within SYNC+1 clocks
    exp_q.push_back(8'h13);
    read_hdr(8'h03, 24'h000004);
    spi_zeros(12);
    check("abort_data_oe_before", {31'h0, spi_bus.io1_oe}, 32'h1);
    half();
    spi_bus.csb = 1'b1;
    repeat (SYNC + 1) @(posedge clock);
    #1;
    check("abort_data_oe_after", {31'h0, spi_bus.io1_oe}, 32'h0);
    repeat (8) @(negedge clock);

`ifdef SPI_FLASH_FAST_READ_EN
    exp_q.push_back(8'h13);
    read_hdr(8'h0B, 24'h000004);
    spi_zeros(8);
    check("fast_dummy_oe", {31'h0, oe_seen}, 32'h0);
    spi_zeros(8);
    cs_high();
`else
    read_hdr(8'h0B, 24'h000004);
    spi_zeros(16);
    check("fast_disabled_oe", {31'h0, oe_seen}, 32'h0);
    cs_high();
`endif

    // Reset in the middle of the second data byte
    exp_q.push_back(8'h13);
    read_hdr(8'h03, 24'h000004);
    spi_zeros(11);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_oe", {31'h0, spi_bus.io1_oe}, 32'h0);
    check("midreset_io1", {31'h0, spi_bus.io1}, 32'h0);
    reset = 1'b0;
    cs_high();

    read_hdr(8'h03, 24'h000004);
    spi_zeros(8);
    check("post_reset_pwrdn_oe", {31'h0, oe_seen}, 32'h0);
    cs_high();

    command(8'hAB);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h57);
    read_hdr(8'h03, 24'h000004);
    spi_zeros(16);
    cs_high();

    command(8'hB9);
    read_hdr(8'h03, 24'h000004);
    spi_zeros(8);
    check("deep_pwrdn_oe", {31'h0, oe_seen}, 32'h0);
    cs_high();

    repeat (10) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
